// File: rtl/argmax_unit.sv
// Streaming argmax: one signed score per beat in class order, emits the winning class index and score.
// Latency: valid_out/err_out pulse in the cycle after the last beat is accepted; min frame period NUM_CLASSES+1.
// Backpressure: in_ready is low only during the single EMIT cycle; bubbles on in_valid hold the frame state.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_score/valid/last   score beat with valid/ready handshake; in_last marks the final class
//   in_ready              registered ready (0 only in EMIT)
//   class_idx, max_score  winning index and score, held until the next good result
//   valid_out, err_out    one-cycle result pulse / frame-length-error pulse
module argmax_unit #(
    parameter int NUM_CLASSES = 2,
    parameter int DATA_W      = 16,
    parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_score,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [CLS_W-1:0]         class_idx,
    output logic [DATA_W-1:0]        max_score,
    output logic                     valid_out,
    output logic                     err_out
);

    // One extra bit so the counter never wraps before the length check.
    localparam int CNT_W = $clog2(NUM_CLASSES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [DATA_W-1:0]  r_run_max;
    logic [CLS_W-1:0]          r_run_idx;
    logic                      r_in_ready;
    logic [CLS_W-1:0]          r_class_idx;
    logic [DATA_W-1:0]         r_max_score;
    logic                      r_valid_out;
    logic                      r_err_out;

    logic                      w_accept;
    logic                      w_take;
    logic                      w_cnt_full;
    logic signed [DATA_W-1:0]  w_next_max;
    logic [CLS_W-1:0]          w_next_idx;

    assign w_accept   = in_valid && r_in_ready;
    // Strict greater-than: on ties the earlier (lower) index keeps the win.
    assign w_take     = (in_score > r_run_max);
    assign w_cnt_full = (r_cnt == LAST_CNT);
    assign w_next_max = w_take ? in_score : r_run_max;
    assign w_next_idx = w_take ? r_cnt[CLS_W-1:0] : r_run_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_in_ready  <= 1'b1;
            r_class_idx <= '0;
            r_max_score <= '0;
            r_valid_out <= 1'b0;
            r_err_out   <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_err_out   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_run_max <= in_score;
                        r_run_idx <= '0;
                        r_cnt     <= CNT_W'(1);
                        if (in_last) begin
                            // Single-beat frame is too short.
                            r_state    <= S_EMIT;
                            r_in_ready <= 1'b0;
                            r_err_out  <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_run_max <= w_next_max;
                        r_run_idx <= w_next_idx;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        if (in_last || w_cnt_full) begin
                            r_state    <= S_EMIT;
                            r_in_ready <= 1'b0;
                            // Results are registered on the final accept so the
                            // pulse lands in the EMIT cycle itself.
                            if (in_last && w_cnt_full) begin
                                r_valid_out <= 1'b1;
                                r_class_idx <= w_next_idx;
                                r_max_score <= w_next_max;
                            end else begin
                                r_err_out <= 1'b1;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    r_cnt      <= '0;
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign class_idx = r_class_idx;
    assign max_score = r_max_score;
    assign valid_out = r_valid_out;
    assign err_out   = r_err_out;

endmodule
